// File: rtl/parser_input_arbiter.sv
// Packet-granular round-robin arbiter sharing one parser receive port between
// NUM_PORTS sources; zero-latency pass-through while streaming, with debug counters.
module parser_input_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_W      = 32,
  parameter int STALL_LIMIT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_data,
  input  logic [NUM_PORTS-1:0]          req_val,
  input  logic [NUM_PORTS-1:0]          req_last,
  output logic [NUM_PORTS-1:0]          req_ready,
  input  logic [NUM_PORTS-1:0]          port_en,
  output logic [DATA_W-1:0]             dataOut,
  output logic                          dataOut_val,
  output logic                          dataOut_last,
  input  logic                          dataOut_ready,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
  output logic                          busy,
  output logic [15:0]                   pkt_count,
  output logic                          stall_err
);
  localparam int GW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(STALL_LIMIT + 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [GW-1:0]   r_grant_id;
  logic [GW-1:0]   w_win_id;
  logic            w_win_found;
  logic [CW-1:0]   r_stall_cnt;
  logic [CW-1:0]   w_stall_inc;
  logic            r_stall_err;
  logic [15:0]     r_pkt_count;
  logic [NUM_PORTS-1:0] w_cand;
  logic            w_g_val;
  logic            w_g_last;
  logic [DATA_W-1:0] w_g_data;
  logic            w_streaming;
  logic            w_beat;

  assign w_cand      = req_val & port_en;
  assign w_g_val     = req_val[r_grant_id];
  assign w_g_last    = req_last[r_grant_id];
  assign w_g_data    = req_data[r_grant_id*DATA_W +: DATA_W];
  assign w_streaming = (r_state == S_STREAM);
  assign w_beat      = w_streaming & w_g_val & dataOut_ready;
  assign w_stall_inc = (r_stall_cnt == CW'(STALL_LIMIT)) ? r_stall_cnt : r_stall_cnt + CW'(1);

  // Scan downward so the last match written is the nearest port after grant_id;
  // grant_id itself (offset NUM_PORTS) therefore has the lowest priority.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = r_grant_id;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (w_cand[(int'(r_grant_id) + i) % NUM_PORTS]) begin
        w_win_found = 1'b1;
        w_win_id    = GW'((int'(r_grant_id) + i) % NUM_PORTS);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_win_found) w_state_next = S_STREAM;
      S_STREAM: if (w_beat && w_g_last) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    dataOut      = '0;
    dataOut_val  = 1'b0;
    dataOut_last = 1'b0;
    if (w_streaming) begin
      dataOut_val             = w_g_val;
      dataOut_last            = w_g_last;
      dataOut                 = w_g_val ? w_g_data : '0;
      req_ready[r_grant_id]   = dataOut_ready;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_grant_id  <= GW'(NUM_PORTS - 1);
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (!w_streaming && w_win_found) r_grant_id <= w_win_id;
      if (w_beat && w_g_last) r_pkt_count <= r_pkt_count + 16'd1;
      // Watchdog only watches the source; parser backpressure is not a stall.
      if (w_streaming && !w_g_val) begin
        r_stall_cnt <= w_stall_inc;
        if (w_stall_inc == CW'(STALL_LIMIT)) r_stall_err <= 1'b1;
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end

  assign grant_id  = r_grant_id;
  assign busy      = w_streaming;
  assign pkt_count = r_pkt_count;
  assign stall_err = r_stall_err;
endmodule
